// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the parallel-in serial-out shifter.
// The master side supplies words. The slave side serializes them.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output parallel_in, load_valid,
        input  load_ready, serial_out, serial_valid, busy, frame_done
    );

    modport slave (
        input  parallel_in, load_valid,
        output load_ready, serial_out, serial_valid, busy, frame_done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load. It emits one bit per clock.
// At the last bit it accepts the next word, so back-to-back frames leave no idle cycle.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    piso_serializer_if.slave  bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // load_ready depends only on state and count. Upstream valid only steers the next state.
    always_comb begin
        state_nxt        = state;
        bus.load_ready   = 1'b0;
        bus.serial_valid = 1'b0;
        bus.busy         = 1'b0;
        bus.serial_out   = 1'b0;
        bus.frame_done   = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                bus.busy         = 1'b1;
                bus.serial_valid = 1'b1;
                bus.serial_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
                if (bit_cnt == LAST) begin
                    bus.frame_done = 1'b1;
                    bus.load_ready = 1'b1;
                    state_nxt      = bus.load_valid ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = bus.load_valid & bus.load_ready;

    // Shifting fills with zeros, so the register is already clear when the FSM reaches IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= bus.parallel_in;
            bit_cnt   <= '0;
        end else if (state == SHIFT) begin
            shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shift_reg[WIDTH-1:1]};
            bit_cnt   <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer. It uses an MSB-first and an LSB-first instance.
// Each instance feeds a bench-side SIPO for loopback.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) a_if ();
    piso_serializer_if #(.WIDTH(8)) b_if ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));

    logic [7:0] sipo_a, sipo_b;
    always @(posedge clk) begin
        if (!reset_n) begin
            sipo_a <= 8'h00;
            sipo_b <= 8'h00;
        end else begin
            if (a_if.serial_valid) sipo_a <= {sipo_a[6:0], a_if.serial_out};
            if (b_if.serial_valid) sipo_b <= {b_if.serial_out, sipo_b[7:1]};
        end
    end

    task automatic send_a(input logic [7:0] w);
        @(negedge clk);
        a_if.parallel_in = w;
        a_if.load_valid  = 1'b1;
        @(posedge clk);
        #1;
        a_if.load_valid  = 1'b0;
        a_if.parallel_in = 8'h00;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++; if (a_if.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", a_if.load_ready); end
        checks++; if (a_if.serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial_out got %b exp 0", a_if.serial_out); end
        checks++; if (a_if.serial_valid !== 1'b0) begin errors++; $display("FAIL reset_serial_valid got %b exp 0", a_if.serial_valid); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_if.busy); end
        checks++; if (a_if.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", a_if.frame_done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (a_if.load_ready !== 1'b1 || a_if.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got rdy=%b busy=%b exp rdy=1 busy=0", a_if.load_ready, a_if.busy); end
    endtask

    task automatic test_frame(input logic [7:0] w, input string name);
        send_a(w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (a_if.serial_out !== w[7-i]) begin errors++; $display("FAIL %s_bit%0d got %b exp %b", name, i, a_if.serial_out, w[7-i]); end
            checks++; if (a_if.serial_valid !== 1'b1 || a_if.busy !== 1'b1) begin errors++; $display("FAIL %s_valid%0d got v=%b b=%b exp 1 1", name, i, a_if.serial_valid, a_if.busy); end
            checks++; if (a_if.frame_done !== (i == 7)) begin errors++; $display("FAIL %s_done%0d got %b exp %b", name, i, a_if.frame_done, (i == 7)); end
        end
        @(negedge clk);
        checks++; if (a_if.serial_valid !== 1'b0 || a_if.frame_done !== 1'b0 || a_if.busy !== 1'b0) begin errors++; $display("FAIL %s_end got v=%b d=%b b=%b exp 0 0 0", name, a_if.serial_valid, a_if.frame_done, a_if.busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = {8'hA5, 8'h3C};
        @(negedge clk);
        a_if.parallel_in = 8'hA5;
        a_if.load_valid  = 1'b1;
        @(posedge clk);
        #1 a_if.parallel_in = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++; if (a_if.serial_out !== stream[15-i]) begin errors++; $display("FAIL b2b_bit%0d got %b exp %b", i, a_if.serial_out, stream[15-i]); end
            checks++; if (a_if.serial_valid !== 1'b1 || a_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got v=%b b=%b exp 1 1", i, a_if.serial_valid, a_if.busy); end
            checks++; if (a_if.frame_done !== (i == 7 || i == 15)) begin errors++; $display("FAIL b2b_done%0d got %b exp %b", i, a_if.frame_done, (i == 7 || i == 15)); end
            if (i == 7) begin
                checks++; if (a_if.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last got %b exp 1", a_if.load_ready); end
                @(posedge clk);
                #1 a_if.load_valid = 1'b0;
                a_if.parallel_in = 8'h00;
            end
        end
        @(negedge clk);
        checks++; if (a_if.serial_valid !== 1'b0 || a_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%b b=%b exp 0 0", a_if.serial_valid, a_if.busy); end
    endtask

    task automatic test_busy();
        logic [15:0] stream;
        stream = {8'h69, 8'hFF};
        send_a(8'h69);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a_if.parallel_in = 8'hFF;
                a_if.load_valid  = 1'b1;
                #1;
            end
            if (i >= 3 && i <= 6) begin
                checks++; if (a_if.load_ready !== 1'b0) begin errors++; $display("FAIL busy_ready%0d got %b exp 0", i, a_if.load_ready); end
            end
            checks++; if (a_if.serial_out !== stream[15-i]) begin errors++; $display("FAIL busy_bit%0d got %b exp %b", i, a_if.serial_out, stream[15-i]); end
            checks++; if (a_if.frame_done !== (i == 7 || i == 15)) begin errors++; $display("FAIL busy_done%0d got %b exp %b", i, a_if.frame_done, (i == 7 || i == 15)); end
            if (i == 7) begin
                checks++; if (a_if.load_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_last got %b exp 1", a_if.load_ready); end
                @(posedge clk);
                #1 a_if.load_valid = 1'b0;
                a_if.parallel_in = 8'h00;
            end
        end
        @(negedge clk);
        checks++; if (a_if.serial_valid !== 1'b0) begin errors++; $display("FAIL busy_end got %b exp 0", a_if.serial_valid); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        w = 8'hF0;
        send_a(w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_if.serial_out !== w[7-i] || a_if.frame_done !== 1'b0) begin errors++; $display("FAIL mrst_bit%0d got %b/%b exp %b/0", i, a_if.serial_out, a_if.frame_done, w[7-i]); end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (a_if.serial_valid !== 1'b0 || a_if.busy !== 1'b0) begin errors++; $display("FAIL mrst_abort got v=%b b=%b exp 0 0", a_if.serial_valid, a_if.busy); end
        checks++; if (a_if.frame_done !== 1'b0 || a_if.load_ready !== 1'b1) begin errors++; $display("FAIL mrst_flags got d=%b r=%b exp 0 1", a_if.frame_done, a_if.load_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (a_if.load_ready !== 1'b1 || a_if.frame_done !== 1'b0) begin errors++; $display("FAIL mrst_idle got r=%b d=%b exp 1 0", a_if.load_ready, a_if.frame_done); end
        test_frame(8'h81, "mrst_81");
    endtask

    task automatic test_loopback();
        logic [7:0] w;
        send_a(8'h5A);
        for (int i = 0; i < 8; i++) @(negedge clk);
        checks++; if (a_if.frame_done !== 1'b1) begin errors++; $display("FAIL loop_a_done got %b exp 1", a_if.frame_done); end
        @(posedge clk);
        #1;
        checks++; if (sipo_a !== 8'h5A) begin errors++; $display("FAIL loop_a_sipo got %h exp 5a", sipo_a); end

        w = 8'h01;
        @(negedge clk);
        b_if.parallel_in = w;
        b_if.load_valid  = 1'b1;
        @(posedge clk);
        #1 b_if.load_valid = 1'b0;
        b_if.parallel_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (b_if.serial_out !== w[i] || b_if.serial_valid !== 1'b1) begin errors++; $display("FAIL loop_b_bit%0d got %b/%b exp %b/1", i, b_if.serial_out, b_if.serial_valid, w[i]); end
            checks++; if (b_if.frame_done !== (i == 7)) begin errors++; $display("FAIL loop_b_done%0d got %b exp %b", i, b_if.frame_done, (i == 7)); end
        end
        @(posedge clk);
        #1;
        checks++; if (sipo_b !== 8'h01) begin errors++; $display("FAIL loop_b_sipo got %h exp 01", sipo_b); end
        @(negedge clk);
        checks++; if (b_if.serial_valid !== 1'b0) begin errors++; $display("FAIL loop_b_end got %b exp 0", b_if.serial_valid); end
    endtask

    initial begin
        a_if.parallel_in = 8'h00;
        a_if.load_valid  = 1'b0;
        b_if.parallel_in = 8'h00;
        b_if.load_valid  = 1'b0;
        test_reset();
        test_frame(8'b11001101, "frame_cd");
        test_back_to_back();
        test_busy();
        test_mid_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
